// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-fetch stage directly upstream of the 16-bit ALU. It holds the
// general register file (R0 hardwired to zero) and the carry flag. It reads two
// source operands, optionally substitutes an immediate for operand B, and
// presents a registered bundle to the ALU under a valid/ready handshake.
// Writeback of ALU results and carry is accepted at any time. A same-cycle
// writeback is bypassed into the captured operands.
//
// Ports
//   clk_in, rst_in            rising-edge clock, synchronous active-high reset
//   issue_valid_in/ready_out  upstream handshake (ready = !valid_out || ready_in)
//   rs_a_in, rs_b_in          source register addresses
//   imm_in, use_imm_in        immediate and its select for operand B
//   use_carry_in              forward carry flag (1) or zero (0) to carry_out
//   alu_sel_in, rd_in         passed through into the bundle
//   wb_en_in/addr/data        register writeback (writes to R0 are ignored)
//   wb_carry_en_in/carry_in   carry flag writeback
//   valid_out, ready_in       downstream handshake
//   a_out, b_out, carry_out,
//   alu_sel_out, rd_out       registered bundle to the ALU
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              issue_valid_in,
  output logic              issue_ready_out,
  input  logic [ADDR_W-1:0] rs_a_in,
  input  logic [ADDR_W-1:0] rs_b_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              use_imm_in,
  input  logic              use_carry_in,
  input  logic [3:0]        alu_sel_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic              wb_en_in,
  input  logic [ADDR_W-1:0] wb_addr_in,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              wb_carry_en_in,
  input  logic              wb_carry_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              carry_out,
  output logic [3:0]        alu_sel_out,
  output logic [ADDR_W-1:0] rd_out
);

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic              carry_flag;

  // Sources of the bundle currently held, kept so a stalled bundle can be
  // refreshed by writebacks that land while the ALU is not consuming.
  logic [ADDR_W-1:0] held_rs_a;
  logic [ADDR_W-1:0] held_rs_b;
  logic              held_use_imm;
  logic              held_use_carry;

  logic              wb_reg_hit;   // a real (non-R0) register write this cycle
  logic              capture;
  logic              stall;
  logic [DATA_W-1:0] fetch_a;
  logic [DATA_W-1:0] fetch_b;
  logic              fetch_carry;

  assign wb_reg_hit      = wb_en_in && (wb_addr_in != '0);
  assign issue_ready_out = !valid_out || ready_in;
  assign capture         = issue_valid_in && issue_ready_out;
  assign stall           = valid_out && !ready_in;

  // Operand fetch with writeback bypass; R0 always reads zero.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    fetch_a     = '0;
    fetch_b     = imm_in;
    fetch_carry = 1'b0;

    if (rs_a_in != '0) begin
      fetch_a = (wb_reg_hit && wb_addr_in == rs_a_in) ? wb_data_in : regs[rs_a_in];
    end

    if (!use_imm_in) begin
      if (rs_b_in == '0) begin
        fetch_b = '0;
      end else begin
        fetch_b = (wb_reg_hit && wb_addr_in == rs_b_in) ? wb_data_in : regs[rs_b_in];
      end
    end

    if (use_carry_in) begin
      fetch_carry = wb_carry_en_in ? wb_carry_in : carry_flag;
    end
  end

  // Register file and carry flag.
  // NOTE: the register file is a handful of flops, not a RAM macro, so it
  // can and must be cleared by reset; a RAM-inferred array could not be.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      carry_flag <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (wb_reg_hit) begin
        regs[wb_addr_in] <= wb_data_in;
      end
      if (wb_carry_en_in) begin
        carry_flag <= wb_carry_in;
      end
    end
  end

  // Output bundle and held sources.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out      <= 1'b0;
      a_out          <= '0;
      b_out          <= '0;
      carry_out      <= 1'b0;
      alu_sel_out    <= '0;
      rd_out         <= '0;
      held_rs_a      <= '0;
      held_rs_b      <= '0;
      held_use_imm   <= 1'b0;
      held_use_carry <= 1'b0;
    end else if (capture) begin
      valid_out      <= 1'b1;
      a_out          <= fetch_a;
      b_out          <= fetch_b;
      carry_out      <= fetch_carry;
      alu_sel_out    <= alu_sel_in;
      rd_out         <= rd_in;
      held_rs_a      <= rs_a_in;
      held_rs_b      <= rs_b_in;
      held_use_imm   <= use_imm_in;
      held_use_carry <= use_carry_in;
    end else if (stall) begin
      // Keep the stalled bundle coherent with the register file so the ALU
      // never consumes an operand that was overwritten while it waited.
      if (wb_reg_hit && wb_addr_in == held_rs_a) begin
        a_out <= wb_data_in;
      end
      if (!held_use_imm && wb_reg_hit && wb_addr_in == held_rs_b) begin
        b_out <= wb_data_in;
      end
      if (held_use_carry && wb_carry_en_in) begin
        carry_out <= wb_carry_in;
      end
    end else if (ready_in) begin
      // Consumed with nothing new: drop valid, data outputs hold.
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Directed testbench for alu_operand_stage. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled at the same point, well away
// from the next active edge.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              issue_valid_in;
  logic              issue_ready_out;
  logic [ADDR_W-1:0] rs_a_in;
  logic [ADDR_W-1:0] rs_b_in;
  logic [DATA_W-1:0] imm_in;
  logic              use_imm_in;
  logic              use_carry_in;
  logic [3:0]        alu_sel_in;
  logic [ADDR_W-1:0] rd_in;
  logic              wb_en_in;
  logic [ADDR_W-1:0] wb_addr_in;
  logic [DATA_W-1:0] wb_data_in;
  logic              wb_carry_en_in;
  logic              wb_carry_in;
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic              carry_out;
  logic [3:0]        alu_sel_out;
  logic [ADDR_W-1:0] rd_out;

  int errors = 0;
  int checks = 0;

  alu_operand_stage #(.DATA_W(DATA_W), .REG_COUNT(8), .ADDR_W(ADDR_W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .issue_valid_in  (issue_valid_in),
    .issue_ready_out (issue_ready_out),
    .rs_a_in         (rs_a_in),
    .rs_b_in         (rs_b_in),
    .imm_in          (imm_in),
    .use_imm_in      (use_imm_in),
    .use_carry_in    (use_carry_in),
    .alu_sel_in      (alu_sel_in),
    .rd_in           (rd_in),
    .wb_en_in        (wb_en_in),
    .wb_addr_in      (wb_addr_in),
    .wb_data_in      (wb_data_in),
    .wb_carry_en_in  (wb_carry_en_in),
    .wb_carry_in     (wb_carry_in),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .a_out           (a_out),
    .b_out           (b_out),
    .carry_out       (carry_out),
    .alu_sel_out     (alu_sel_out),
    .rd_out          (rd_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [2:0] ra, input logic [2:0] rb,
                           input logic ui, input logic [15:0] imm, input logic uc,
                           input logic [3:0] sel, input logic [2:0] rd);
    issue_valid_in = v;
    rs_a_in        = ra;
    rs_b_in        = rb;
    use_imm_in     = ui;
    imm_in         = imm;
    use_carry_in   = uc;
    alu_sel_in     = sel;
    rd_in          = rd;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] addr, input logic [15:0] data);
    wb_en_in   = en;
    wb_addr_in = addr;
    wb_data_in = data;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    set_issue(1'b0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 4'h0, 3'd0);
    set_wb(1'b0, 3'd0, 16'h0);
    wb_carry_en_in = 1'b0;
    wb_carry_in    = 1'b0;
    ready_in       = 1'b0;
    tick();
    tick();
    rst_in = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (a_out !== 16'h0) begin errors++; $display("FAIL reset_a: got %h want 0000", a_out); end
    checks++; if (b_out !== 16'h0) begin errors++; $display("FAIL reset_b: got %h want 0000", b_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry_out); end
    checks++; if (alu_sel_out !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", alu_sel_out); end
    checks++; if (rd_out !== 3'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
    checks++; if (issue_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready_out); end
  endtask

  task automatic test_basic_read();
    ready_in = 1'b1;
    set_wb(1'b1, 3'd3, 16'h1234); tick();
    set_wb(1'b1, 3'd5, 16'h00FF); tick();
    set_wb(1'b0, 3'd0, 16'h0);
    set_issue(1'b1, 3'd3, 3'd5, 1'b0, 16'h0, 1'b0, 4'b0000, 3'd1);
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", valid_out); end
    checks++; if (a_out !== 16'h1234) begin errors++; $display("FAIL basic_a: got %h want 1234", a_out); end
    checks++; if (b_out !== 16'h00FF) begin errors++; $display("FAIL basic_b: got %h want 00ff", b_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b want 0", carry_out); end
    checks++; if (rd_out !== 3'd1) begin errors++; $display("FAIL basic_rd: got %0d want 1", rd_out); end
    issue_valid_in = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", valid_out); end
    checks++; if (a_out !== 16'h1234) begin errors++; $display("FAIL drain_hold_a: got %h want 1234", a_out); end
  endtask

  task automatic test_bypass_and_r0();
    set_wb(1'b1, 3'd2, 16'hBEEF);
    set_issue(1'b1, 3'd2, 3'd2, 1'b0, 16'h0, 1'b0, 4'h1, 3'd2);
    tick();
    checks++; if (a_out !== 16'hBEEF) begin errors++; $display("FAIL bypass_a: got %h want beef", a_out); end
    checks++; if (b_out !== 16'hBEEF) begin errors++; $display("FAIL bypass_b: got %h want beef", b_out); end
    issue_valid_in = 1'b0;
    set_wb(1'b1, 3'd0, 16'hFFFF); tick();
    set_wb(1'b0, 3'd0, 16'h0);
    set_issue(1'b1, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0, 4'h1, 3'd0);
    tick();
    checks++; if (a_out !== 16'h0000) begin errors++; $display("FAIL r0_a: got %h want 0000", a_out); end
    checks++; if (b_out !== 16'h0000) begin errors++; $display("FAIL r0_b: got %h want 0000", b_out); end
    issue_valid_in = 1'b0;
  endtask

  task automatic test_imm_and_carry();
    set_wb(1'b1, 3'd4, 16'h0007); tick();
    set_wb(1'b0, 3'd0, 16'h0);
    set_issue(1'b1, 3'd4, 3'd4, 1'b1, 16'h8001, 1'b0, 4'h2, 3'd3);
    tick();
    checks++; if (b_out !== 16'h8001) begin errors++; $display("FAIL imm_b: got %h want 8001", b_out); end
    checks++; if (a_out !== 16'h0007) begin errors++; $display("FAIL imm_a: got %h want 0007", a_out); end
    use_imm_in = 1'b0;
    tick();
    checks++; if (b_out !== 16'h0007) begin errors++; $display("FAIL reg_b: got %h want 0007", b_out); end
    issue_valid_in = 1'b0;
    wb_carry_en_in = 1'b1; wb_carry_in = 1'b1; tick();
    wb_carry_en_in = 1'b0;
    issue_valid_in = 1'b1; use_carry_in = 1'b1; tick();
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL carry_use: got %b want 1", carry_out); end
    use_carry_in = 1'b0; tick();
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL carry_nouse: got %b want 0", carry_out); end
    // Carry bypass in both directions.
    use_carry_in = 1'b1; wb_carry_en_in = 1'b1; wb_carry_in = 1'b0; tick();
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL carry_bypass0: got %b want 0", carry_out); end
    wb_carry_in = 1'b1; tick();
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL carry_bypass1: got %b want 1", carry_out); end
    wb_carry_en_in = 1'b0;
    issue_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_stall_refresh();
    // Flag is 1, R6 = 0, R3 = 1234, R5 = 00FF.
    ready_in = 1'b0;
    set_issue(1'b1, 3'd6, 3'd3, 1'b0, 16'h0, 1'b1, 4'h3, 3'd6);
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", valid_out); end
    checks++; if (a_out !== 16'h0000) begin errors++; $display("FAIL stall_a0: got %h want 0000", a_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL stall_c0: got %b want 1", carry_out); end
    checks++; if (issue_ready_out !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", issue_ready_out); end
    // New instruction waits while held operands are refreshed.
    set_issue(1'b1, 3'd5, 3'd5, 1'b0, 16'h0, 1'b0, 4'h9, 3'd2);
    set_wb(1'b1, 3'd6, 16'h0A0A);
    wb_carry_en_in = 1'b1; wb_carry_in = 1'b0;
    tick();
    checks++; if (a_out !== 16'h0A0A) begin errors++; $display("FAIL refresh_a: got %h want 0a0a", a_out); end
    checks++; if (b_out !== 16'h1234) begin errors++; $display("FAIL refresh_b_keep: got %h want 1234", b_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL refresh_c: got %b want 0", carry_out); end
    checks++; if (alu_sel_out !== 4'h3) begin errors++; $display("FAIL stall_sel: got %h want 3", alu_sel_out); end
    checks++; if (issue_ready_out !== 1'b0) begin errors++; $display("FAIL stall_ready2: got %b want 0", issue_ready_out); end
    wb_carry_en_in = 1'b0;
    set_wb(1'b1, 3'd3, 16'h4321);
    tick();
    checks++; if (b_out !== 16'h4321) begin errors++; $display("FAIL refresh_b: got %h want 4321", b_out); end
    checks++; if (a_out !== 16'h0A0A) begin errors++; $display("FAIL refresh_a_keep: got %h want 0a0a", a_out); end
    set_wb(1'b0, 3'd0, 16'h0);
    ready_in = 1'b1;
    #1;
    checks++; if (issue_ready_out !== 1'b1) begin errors++; $display("FAIL unstall_ready: got %b want 1", issue_ready_out); end
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL unstall_valid: got %b want 1", valid_out); end
    checks++; if (alu_sel_out !== 4'h9) begin errors++; $display("FAIL unstall_sel: got %h want 9", alu_sel_out); end
    checks++; if (a_out !== 16'h00FF) begin errors++; $display("FAIL unstall_a: got %h want 00ff", a_out); end
    checks++; if (rd_out !== 3'd2) begin errors++; $display("FAIL unstall_rd: got %0d want 2", rd_out); end
    issue_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ra  [4] = '{3'd3, 3'd2, 3'd4, 3'd6};
    logic [15:0] exp [4] = '{16'h4321, 16'hBEEF, 16'h0007, 16'h0A0A};
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_issue(1'b1, ra[i], 3'd0, 1'b0, 16'h0, 1'b0, 4'(i + 1), 3'(i));
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, valid_out); end
      checks++; if (a_out !== exp[i]) begin errors++; $display("FAIL b2b_a[%0d]: got %h want %h", i, a_out, exp[i]); end
      checks++; if (alu_sel_out !== 4'(i + 1)) begin errors++; $display("FAIL b2b_sel[%0d]: got %h want %h", i, alu_sel_out, 4'(i + 1)); end
    end
    issue_valid_in = 1'b0;
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", valid_out); end
    checks++; if (a_out !== 16'h0A0A) begin errors++; $display("FAIL b2b_hold: got %h want 0a0a", a_out); end
  endtask

  task automatic test_reset_mid_stall();
    set_wb(1'b1, 3'd1, 16'h5555);
    wb_carry_en_in = 1'b1; wb_carry_in = 1'b1;
    tick();
    set_wb(1'b0, 3'd0, 16'h0);
    wb_carry_en_in = 1'b0;
    ready_in = 1'b0;
    set_issue(1'b1, 3'd1, 3'd1, 1'b0, 16'h0, 1'b1, 4'hA, 3'd5);
    tick();
    checks++; if (a_out !== 16'h5555) begin errors++; $display("FAIL prerst_a: got %h want 5555", a_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL prerst_c: got %b want 1", carry_out); end
    // Reset must win over a concurrent issue and writeback.
    rst_in = 1'b1;
    set_wb(1'b1, 3'd7, 16'hFFFF);
    tick();
    rst_in = 1'b0;
    set_wb(1'b0, 3'd0, 16'h0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_out); end
    checks++; if (a_out !== 16'h0 || b_out !== 16'h0) begin errors++; $display("FAIL rst_ab: got %h/%h want 0000/0000", a_out, b_out); end
    checks++; if (carry_out !== 1'b0 || alu_sel_out !== 4'h0 || rd_out !== 3'd0) begin errors++; $display("FAIL rst_misc: got c=%b sel=%h rd=%0d want 0/0/0", carry_out, alu_sel_out, rd_out); end
    ready_in = 1'b1;
    set_issue(1'b1, 3'd1, 3'd7, 1'b0, 16'h0, 1'b1, 4'h1, 3'd1);
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL postrst_valid: got %b want 1", valid_out); end
    checks++; if (a_out !== 16'h0000) begin errors++; $display("FAIL postrst_r1: got %h want 0000", a_out); end
    checks++; if (b_out !== 16'h0000) begin errors++; $display("FAIL postrst_r7: got %h want 0000", b_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL postrst_carry: got %b want 0", carry_out); end
    issue_valid_in = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_bypass_and_r0();
    test_imm_and_carry();
    test_stall_refresh();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the 16-bit ALU.
- Holds the 8-entry general register file and the carry flag.
- Reads two source operands, optionally substitutes an immediate for operand B, and presents a_out/b_out/carry_out/alu_sel_out as a registered bundle to the ALU inputs under a valid/ready handshake.
- Accepts writeback of ALU results and carry, with same-cycle bypass.

Parameters:
- DATA_W, 16, operand/register width
- REG_COUNT, 8, number of registers (R0 hardwired to zero)
- ADDR_W, 3, register address width; must equal clog2(REG_COUNT)

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  synchronous, active-high reset
- issue_valid_in  input  1  upstream instruction valid
- issue_ready_out  output  1  stage can accept an instruction this cycle
- rs_a_in  input  ADDR_W  source register for operand A
- rs_b_in  input  ADDR_W  source register for operand B
- imm_in  input  DATA_W  immediate value
- use_imm_in  input  1  1: B = imm_in, 0: B = R[rs_b_in]
- use_carry_in  input  1  1: carry_out = carry flag, 0: carry_out = 0
- alu_sel_in  input  4  ALU operation select, passed through
- rd_in  input  ADDR_W  destination register, passed through
- wb_en_in  input  1  register write enable
- wb_addr_in  input  ADDR_W  write address
- wb_data_in  input  DATA_W  write data
- wb_carry_en_in  input  1  carry flag write enable
- wb_carry_in  input  1  new carry flag value
- valid_out  output  1  output bundle valid
- ready_in  input  1  downstream consumes bundle this cycle
- a_out  output  DATA_W  operand A to ALU a_in
- b_out  output  DATA_W  operand B to ALU b_in
- carry_out  output  1  carry to ALU c_in
- alu_sel_out  output  4  registered alu_sel
- rd_out  output  ADDR_W  registered destination

Behaviour:
- Reset (rst_in=1 at edge):
  - All registers R0..R7 := 0; carry flag := 0.
  - valid_out, a_out, b_out, carry_out, alu_sel_out, rd_out := 0.
  - Held bundle discarded; reset overrides any concurrent issue or writeback.
- R0:
  - Always reads 0.
  - wb_en_in with wb_addr_in=0 is ignored.
- Writeback: R[wb_addr_in] := wb_data_in at the edge when wb_en_in=1 and wb_addr_in≠0. Same rule for the carry flag with wb_carry_en_in. Writeback is independent of the handshake.
- Read bypass: if wb_en_in=1, wb_addr_in≠0 and wb_addr_in equals a source address, the captured operand is wb_data_in rather than the stale register. Likewise, carry_out captures wb_carry_in when wb_carry_en_in=1 and use_carry_in=1.
- Handshake:
  - issue_ready_out = !valid_out || ready_in (combinational).
  - Capture occurs when issue_valid_in && issue_ready_out.
  - On capture: valid_out := 1, outputs load the fetched/bypassed values; latency is 1 cycle issue→valid_out.
  - If no capture and ready_in=1: valid_out := 0 and data outputs hold their last values.
  - Capture and consume in the same cycle: back-to-back, valid_out stays 1 and the new bundle loads.
- Held-operand refresh: while valid_out=1 and ready_in=0, the stage retains the held rs_a/rs_b/use_imm/use_carry.
  - A writeback in a stall cycle matching a held source (nonzero; B only if use_imm=0) updates a_out/b_out at that edge.
  - A carry writeback updates carry_out if the held use_carry=1.
  - Guarantees that the ALU never consumes a stale operand.
- Issue accepted with issue_valid_in=0: no state change except writeback.
- No arithmetic is performed in this block; widths pass through unchanged, with no extension or truncation.

Test Plan:
- Reset, then write R3=0x1234 and R5=0x00FF, then issue rs_a=3, rs_b=5, alu_sel=0000, use_carry=0 → next cycle valid_out=1, a_out=0x1234, b_out=0x00FF, carry_out=0.
- Write R2=0xBEEF in the same cycle as issuing rs_a=2 → a_out=0xBEEF (bypass). Separately, write to R0=0xFFFF, then issue rs_a=0 → a_out=0x0000.
- Issue with use_imm=1, imm=0x8001, rs_b=4 (R4=0x0007) → b_out=0x8001. Set carry flag via wb_carry_en=1, wb_carry=1, then issue use_carry=1 → carry_out=1; with use_carry=0 → carry_out=0.
- Hold ready_in=0 with valid_out=1 (rs_a=6), write R6=0x0A0A → a_out becomes 0x0A0A next cycle, issue_ready_out=0, and the new issue is not captured until ready_in=1.
- Continuous issue_valid_in=1 and ready_in=1 over 4 instructions → valid_out stays 1, one bundle per cycle, no drops or duplicates. Then ready_in=1, issue_valid_in=0 → valid_out=0.
- Assert rst_in mid-stall with valid_out=1 and R1=0x5555 → next cycle valid_out=0, all outputs 0, a subsequent read of R1 returns 0, and carry flag=0.
